cmd_rw_scheduler: RTL
=====================

Name: cmd_rw_scheduler

Overview:
Command scheduler between the eight bank machines plus the refresher and the DFI command path. Each cycle it picks one bank machine command by round-robin within the current bus direction. It switches between READ and WRITE phases using time budgets and turnaround latencies, and it grants the refresher exclusive access when requested.

Parameters:
NBANK, 8, number of bank machine requesters; the index width is $clog2(NBANK).
CNT_W, 8, width of all time and latency counters; matches the CSR width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
bank_valid  in  NBANK  bank i has a command pending
bank_is_read  in  NBANK  pending command is a read CAS
bank_is_write  in  NBANK  pending command is a write CAS; if neither read nor write is set, it is a row command (ACT/PRE)
bank_ready  out  NBANK  one-hot accept; handshake completes when bank_valid[i] & bank_ready[i]
cmd_ready  in  1  downstream command slot is free this cycle
ref_valid  in  1  refresher requests the bus
ref_ready  out  1  refresher owns the bus
sel_valid  out  1  a bank command is issued this cycle
sel_bank  out  $clog2(NBANK)  index of the issued bank
sel_is_read  out  1  the issued command is a read
sel_is_write  out  1  the issued command is a write
dir_write  out  1  current data direction: 0 = read, 1 = write
read_time_cfg  in  CNT_W  minimum READ-phase cycles before yielding to writes
write_time_cfg  in  CNT_W  minimum WRITE-phase cycles before yielding to reads
rtw_latency_cfg  in  CNT_W  read-to-write turnaround cycles
wtr_latency_cfg  in  CNT_W  write-to-read turnaround cycles

Behaviour:
- States: READ (reset state), WRITE, RTW, WTR, REFRESH. One state register plus one phase_cnt and one rr_ptr. All are reset asynchronously when rst = 0.
- Reset values: state = READ, phase_cnt = 0, rr_ptr = 0. All outputs are 0: bank_ready, ref_ready, sel_* and dir_write.
- Eligibility:
  - READ: bank_valid & ~bank_is_write
  - WRITE: bank_valid & ~bank_is_read
  - RTW, WTR, REFRESH: nothing is eligible
- Grant (combinational):
  - The first eligible index searching from rr_ptr upward, with wrap-around NBANK-1 → 0.
  - bank_ready is one-hot on that index only when cmd_ready = 1 and ref_valid = 0.
  - sel_valid = the handshake; sel_bank / sel_is_read / sel_is_write describe the granted command.
- On each handshake: rr_ptr <= granted index + 1, wrapping to 0 after NBANK-1.
- phase_cnt in READ/WRITE:
  - Cleared on entry.
  - Increments each cycle and saturates at all-ones.
  - "budget met" means phase_cnt >= read_time_cfg (READ) or phase_cnt >= write_time_cfg (WRITE).
- Transitions (priority top to bottom):
  - READ/WRITE with ref_valid = 1: go to REFRESH next cycle. No bank grant is made in the cycle ref_valid is seen.
  - READ: if a write is pending (any bank_valid & bank_is_write) and (budget met or no read pending): go to RTW and load phase_cnt = rtw_latency_cfg.
  - WRITE: symmetric, going to WTR with wtr_latency_cfg.
  - RTW/WTR: decrement phase_cnt. Leave for WRITE/READ respectively in the cycle after phase_cnt == 0. A cfg value of 0 gives exactly one cycle in RTW/WTR.
  - REFRESH: ref_ready = 1. When ref_valid falls, return to READ next cycle.
  - ref_valid arriving during RTW/WTR is honoured only after the turnaround completes.
- dir_write = 1 in WRITE and RTW, 0 in READ, WTR and REFRESH.
- Row commands are eligible in both READ and WRITE, and never by themselves trigger a direction switch.
- cmd_ready = 0: no grant, and rr_ptr is held; counters and transitions still run.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously). Any in-flight grant is dropped.

Optional Feature:
CMD_SCHED_TURNAROUND_CNT_EN:
- Defined: adds output turnaround_cnt[15:0].
  - Increments on every entry into RTW or WTR and saturates at 0xFFFF.
  - Cleared by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then banks 0, 3 and 5 issue reads continuously with cmd_ready = 1 → grants go 0, 3, 5, 0, … one per cycle; dir_write stays 0.
2. read_time_cfg = 4 and rtw_latency_cfg = 2; bank 2 writes while banks 0 and 1 read → switch to RTW only after ≥ 4 READ cycles; 3 idle cycles; then bank 2 is granted with dir_write = 1.
3. Only a write pending at reset (no reads), rtw_latency_cfg = 0 → RTW for 1 cycle; the write is granted on cycle 2 after leaving READ.
4. ref_valid raised during WRITE with 8 writes pending → no grant in that cycle; ref_ready = 1 next cycle; ref_valid held 10 cycles; return to READ, with writes resumed via the RTW path.
5. cmd_ready toggled 1 / 0 with all 8 banks reading → grants only in cmd_ready = 1 cycles, strictly in order 0 through 7; rr_ptr does not advance in stalled cycles.
6. Assert rst during RTW with phase_cnt = 3 → all outputs are 0 at once; after release, state = READ and the first grant goes to the lowest-index eligible bank.

Source files
------------

// File: rtl/cmd_rw_scheduler.sv
// Command scheduler between NBANK bank machines, the refresher and the DFI
// command path. Round-robin grant within the current bus direction, with
// time-budgeted READ/WRITE phases separated by RTW/WTR turnaround states.
// Optional build macro CMD_SCHED_TURNAROUND_CNT_EN adds a saturating count of
// turnaround entries on output turnaround_cnt.
module cmd_rw_scheduler #(
    parameter int unsigned NBANK = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBANK-1:0]         bank_valid,
    input  logic [NBANK-1:0]         bank_is_read,
    input  logic [NBANK-1:0]         bank_is_write,
    output logic [NBANK-1:0]         bank_ready,
    input  logic                     cmd_ready,
    input  logic                     ref_valid,
    output logic                     ref_ready,
    output logic                     sel_valid,
    output logic [$clog2(NBANK)-1:0] sel_bank,
    output logic                     sel_is_read,
    output logic                     sel_is_write,
    output logic                     dir_write,
    input  logic [CNT_W-1:0]         read_time_cfg,
    input  logic [CNT_W-1:0]         write_time_cfg,
    input  logic [CNT_W-1:0]         rtw_latency_cfg,
    input  logic [CNT_W-1:0]         wtr_latency_cfg
`ifdef CMD_SCHED_TURNAROUND_CNT_EN
    ,
    output logic [15:0]              turnaround_cnt
`endif
);

    localparam int unsigned IdxW = $clog2(NBANK);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBANK - 1);

    typedef enum logic [2:0] {
        StRead,
        StWrite,
        StRtw,
        StWtr,
        StRefresh
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NBANK-1:0]  eligible;
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   grant_idx;
    logic              grant_found;
    logic              grant_en;
    logic              handshake;
    logic              any_rd;
    logic              any_wr;
    logic [CNT_W-1:0]  cnt_inc;

    // Reset gates the grant so no handshake can leak out while rst is low.
    assign grant_en  = rst & cmd_ready & ~ref_valid;
    assign handshake = grant_en & grant_found;
    assign any_rd    = |(bank_valid & bank_is_read);
    assign any_wr    = |(bank_valid & bank_is_write);
    assign cnt_inc   = (&phase_cnt_q) ? phase_cnt_q : phase_cnt_q + 1'b1;

    // Eligibility by direction and round-robin search starting at rr_ptr.
    always_comb begin
        eligible = '0;
        case (state_q)
            StRead:  eligible = bank_valid & ~bank_is_write;
            StWrite: eligible = bank_valid & ~bank_is_read;
            default: eligible = '0;
        endcase
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            cand = IdxW'((32'(rr_ptr_q) + i) % NBANK);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State, phase counter and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRead;
            phase_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Next state: refresh first, then direction switch, then budget counting.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
        end
        case (state_q)
            StRead: begin
                if (ref_valid) begin
                    state_d = StRefresh;
                end else if (any_wr && ((phase_cnt_q >= read_time_cfg) || !any_rd)) begin
                    state_d     = StRtw;
                    phase_cnt_d = rtw_latency_cfg;
                end else begin
                    phase_cnt_d = cnt_inc;
                end
            end
            StWrite: begin
                if (ref_valid) begin
                    state_d = StRefresh;
                end else if (any_rd && ((phase_cnt_q >= write_time_cfg) || !any_wr)) begin
                    state_d     = StWtr;
                    phase_cnt_d = wtr_latency_cfg;
                end else begin
                    phase_cnt_d = cnt_inc;
                end
            end
            StRtw: begin
                if (phase_cnt_q == '0) begin
                    state_d     = StWrite;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q - 1'b1;
                end
            end
            StWtr: begin
                if (phase_cnt_q == '0) begin
                    state_d     = StRead;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q - 1'b1;
                end
            end
            StRefresh: begin
                if (!ref_valid) begin
                    state_d     = StRead;
                    phase_cnt_d = '0;
                end
            end
            default: begin
                state_d     = StRead;
                phase_cnt_d = '0;
            end
        endcase
    end

    // Outputs: one-hot accept and selected command description.
    always_comb begin
        bank_ready   = '0;
        sel_valid    = handshake;
        sel_bank     = '0;
        sel_is_read  = 1'b0;
        sel_is_write = 1'b0;
        if (handshake) begin
            bank_ready[grant_idx] = 1'b1;
            sel_bank              = grant_idx;
            sel_is_read           = bank_is_read[grant_idx];
            sel_is_write          = bank_is_write[grant_idx];
        end
        dir_write = (state_q == StWrite) || (state_q == StRtw);
        ref_ready = (state_q == StRefresh);
    end

`ifdef CMD_SCHED_TURNAROUND_CNT_EN
    logic turn_entry;
    assign turn_entry = ((state_d == StRtw) && (state_q != StRtw)) ||
                        ((state_d == StWtr) && (state_q != StWtr));

    // Saturating count of entries into either turnaround state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            turnaround_cnt <= '0;
        end else if (turn_entry && (turnaround_cnt != 16'hFFFF)) begin
            turnaround_cnt <= turnaround_cnt + 16'd1;
        end
    end
`endif

endmodule
